// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operand/destination info, branch resolution
// and the stall/flush/forwarding results exchanged with the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              br_taken;
    logic              stall;
    logic              ifid_flush;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic [15:0]       stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_reg_write, id_is_load, br_taken,
        input  stall, ifid_flush, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_reg_write, id_is_load, br_taken,
        output stall, ifid_flush, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes in DEPTH post-decode
// slots (slot 0 = EX, slot DEPTH-1 = WB), raises the ID stall, flushes IF/ID
// on a taken branch and registers the EX operand forwarding selects.
// Optional build macro HAZ_RF_BYPASS_EN: register file is write-through, so a
// producer sitting in the last slot needs neither a stall nor a forward.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_READY = 2,
    parameter int BR_STAGE   = 1,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input logic                Clk,
    input logic                Reset,
    hazard_scoreboard_if.slave hz
);

    typedef struct packed {
        logic             hold;
        logic [SEL_W-1:0] sel;
    } look_t;

    logic [DEPTH-1:0]             slotValid;
    logic [DEPTH-1:0][REG_AW-1:0] slotRd;
    logic [DEPTH-1:0]             slotIsLoad;
    logic [SEL_W-1:0]             fwdA;
    logic [SEL_W-1:0]             fwdB;
    logic [15:0]                  stallCnt;
    look_t                        lookA;
    look_t                        lookB;
    logic                         stallInt;
    logic                         enterSlot0;

    // Youngest producer wins: scan oldest to youngest so the lowest slot
    // index is the last one to overwrite the result.
    function automatic look_t lookup(input logic [REG_AW-1:0] src,
                                     input logic used,
                                     input logic [DEPTH-1:0] vld,
                                     input logic [DEPTH-1:0][REG_AW-1:0] rd,
                                     input logic [DEPTH-1:0] ld);
        look_t r;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && (src != '0) && vld[k] && (rd[k] == src)) begin
                if (k == DEPTH - 1) begin
`ifdef HAZ_RF_BYPASS_EN
                    r = '0;
`else
                    r.hold = 1'b1;
                    r.sel  = '0;
`endif
                end else begin
                    r.hold = ((k + 1) < (ld[k] ? LOAD_READY : 1));
                    r.sel  = SEL_W'(k + 1);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Operand hazard lookup, stall/flush decision and slot-0 admission.
    always_comb begin
        lookA      = lookup(hz.id_rs, hz.id_rs_used, slotValid, slotRd, slotIsLoad);
        lookB      = lookup(hz.id_rt, hz.id_rt_used, slotValid, slotRd, slotIsLoad);
        stallInt   = hz.id_valid && (lookA.hold || lookB.hold) && !hz.br_taken;
        enterSlot0 = hz.id_valid && !stallInt && !hz.br_taken;
    end

    // Control state: slot valids, forwarding selects and the stall counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slotValid <= '0;
            fwdA      <= '0;
            fwdB      <= '0;
            stallCnt  <= '0;
        end else begin
            // ID -> slot 0 boundary
            slotValid[0] <= enterSlot0 && hz.id_reg_write;
            // slot k-1 -> slot k boundaries; wrong-path slots die on a taken branch
            for (int k = 1; k < DEPTH; k++) begin
                slotValid[k] <= slotValid[k-1] && !(hz.br_taken && ((k - 1) < BR_STAGE));
            end
            fwdA <= enterSlot0 ? lookA.sel : '0;
            fwdB <= enterSlot0 ? lookB.sel : '0;
            if (stallInt) begin
                stallCnt <= satInc(stallCnt);
            end
        end
    end

    // Destination and load flag travel with the slots; no reset needed since
    // they are qualified by slotValid.
    always_ff @(posedge Clk) begin
        slotRd[0]     <= hz.id_rd;
        slotIsLoad[0] <= hz.id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            slotRd[k]     <= slotRd[k-1];
            slotIsLoad[k] <= slotIsLoad[k-1];
        end
    end

    assign hz.stall      = stallInt;
    assign hz.ifid_flush = hz.br_taken;
    assign hz.fwd_a      = fwdA;
    assign hz.fwd_b      = fwdB;
    assign hz.stall_cnt  = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic, checked
// against an in-flight instruction list model kept in the bench.
module tb_hazard_scoreboard;

    localparam int DEPTH      = 3;
    localparam int REG_AW     = 5;
    localparam int LOAD_READY = 2;
    localparam int BR_STAGE   = 1;
    localparam int SEL_W      = 2;

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.REG_AW(REG_AW), .SEL_W(SEL_W)) hz ();

    hazard_scoreboard #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_READY(LOAD_READY),
        .BR_STAGE(BR_STAGE), .SEL_W(SEL_W)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-flight writer: age = cycles since it entered EX (age == slot index).
    typedef struct {
        logic [REG_AW-1:0] rd;
        bit                ld;
        int                age;
    } ent_t;

    ent_t        q[$];
    int          mFwdA;
    int          mFwdB;
    logic [15:0] mCnt;
    int          nAssert;
    int          nFail;
    logic        lastStall;
    logic        lastFlush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: nearest in-flight writer of src decides; its distance from ID
    // versus its result availability gives stall and select.
    function automatic void look(input logic [REG_AW-1:0] src, input bit used,
                                 output bit st, output int sel);
        int best;
        best = -1;
        st   = 1'b0;
        sel  = 0;
        if (!used || src == '0) return;
        foreach (q[i]) begin
            if (q[i].rd == src && (best < 0 || q[i].age < q[best].age)) best = i;
        end
        if (best < 0) return;
        if (q[best].age == DEPTH - 1) begin
`ifndef HAZ_RF_BYPASS_EN
            st = 1'b1;
`endif
            return;
        end
        sel = q[best].age + 1;
        st  = ((q[best].ld ? LOAD_READY : 1) > sel);
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit ru, input bit rtu,
                         input int rd, input bit rw, input bit ld, input bit br);
        hz.id_valid     = v;
        hz.id_rs        = REG_AW'(rs);
        hz.id_rt        = REG_AW'(rt);
        hz.id_rs_used   = ru;
        hz.id_rt_used   = rtu;
        hz.id_rd        = REG_AW'(rd);
        hz.id_reg_write = rw;
        hz.id_is_load   = ld;
        hz.br_taken     = br;
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic cycle();
        bit   sa, sb, expStall, enter, br, rw, ld, rs;
        int   selA, selB;
        logic [REG_AW-1:0] rd;
        ent_t e;
        ent_t nq[$];
        #1;
        look(hz.id_rs, hz.id_rs_used, sa, selA);
        look(hz.id_rt, hz.id_rt_used, sb, selB);
        br       = hz.br_taken;
        expStall = hz.id_valid && (sa || sb) && !br;
        enter    = hz.id_valid && !expStall && !br;
        rw       = hz.id_reg_write;
        ld       = hz.id_is_load;
        rd       = hz.id_rd;
        rs       = rst;
        lastStall = hz.stall;
        lastFlush = hz.ifid_flush;
        chk("stall", hz.stall, expStall);
        chk("ifid_flush", hz.ifid_flush, br);
        @(posedge clk);
        if (rs) begin
            q.delete();
            mFwdA = 0;
            mFwdB = 0;
            mCnt  = '0;
        end else begin
            if (expStall && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
            nq = {};
            foreach (q[i]) begin
                if (q[i].age + 1 < DEPTH && !(br && q[i].age < BR_STAGE)) begin
                    e = q[i];
                    e.age = e.age + 1;
                    nq.push_back(e);
                end
            end
            if (enter && rw) begin
                e.rd  = rd;
                e.ld  = ld;
                e.age = 0;
                nq.push_back(e);
            end
            q = nq;
            mFwdA = enter ? selA : 0;
            mFwdB = enter ? selB : 0;
        end
        #1;
        chk("fwd_a", hz.fwd_a, mFwdA);
        chk("fwd_b", hz.fwd_b, mFwdB);
        chk("stall_cnt", hz.stall_cnt, mCnt);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        nAssert = 0;
        nFail   = 0;
        mFwdA   = 0;
        mFwdB   = 0;
        mCnt    = '0;

        // reset
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_fwd_a", hz.fwd_a, 0);
        chk("rst_fwd_b", hz.fwd_b, 0);
        chk("rst_cnt", hz.stall_cnt, 0);
        idle(1);
        chk("rst_stall", lastStall, 0);

        // add r1 ; add r2,r1,r1
        drive(1, 2, 3, 1, 1, 1, 1, 0, 0); cycle();
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0); cycle();
        chk("alu_stall", lastStall, 0);
        chk("alu_fwd_a", hz.fwd_a, 1);
        chk("alu_fwd_b", hz.fwd_b, 1);
        idle(3);

        // lw r1 ; add r3,r1,r4
        drive(1, 9, 0, 1, 0, 1, 1, 1, 0); cycle();
        drive(1, 1, 4, 1, 1, 3, 1, 0, 0); cycle();
        chk("lu_stall1", lastStall, 1);
        chk("lu_bubble_fwd", hz.fwd_a, 0);
        cycle();
        chk("lu_stall2", lastStall, 0);
        chk("lu_fwd_a", hz.fwd_a, 2);
        chk("lu_fwd_b", hz.fwd_b, 0);
        chk("lu_cnt", hz.stall_cnt, 1);
        idle(3);

        // add r0 ; add r5,r0,r0
        drive(1, 2, 3, 1, 1, 0, 1, 0, 0); cycle();
        drive(1, 0, 0, 1, 1, 5, 1, 0, 0); cycle();
        chk("r0_stall", lastStall, 0);
        chk("r0_fwd_a", hz.fwd_a, 0);
        chk("r0_fwd_b", hz.fwd_b, 0);
        idle(3);

        // load-use stall overridden by a taken branch
        drive(1, 9, 0, 1, 0, 1, 1, 1, 0); cycle();
        drive(1, 1, 1, 1, 1, 3, 1, 0, 1); cycle();
        chk("br_stall", lastStall, 0);
        chk("br_flush", lastFlush, 1);
        chk("br_cnt", hz.stall_cnt, 1);
        drive(1, 1, 1, 1, 1, 3, 1, 0, 0); cycle();
        chk("br_slot1_gone", lastStall, 0);
        chk("br_fwd_a", hz.fwd_a, 0);
        idle(3);

        // producer of r7 in the last slot
        drive(1, 2, 3, 1, 1, 7, 1, 0, 0); cycle();
        idle(2);
        drive(1, 7, 7, 1, 1, 6, 1, 0, 0); cycle();
`ifdef HAZ_RF_BYPASS_EN
        chk("wb_stall", lastStall, 0);
        chk("wb_fwd_a", hz.fwd_a, 0);
`else
        chk("wb_stall1", lastStall, 1);
        cycle();
        chk("wb_stall2", lastStall, 0);
        chk("wb_fwd_a", hz.fwd_a, 0);
        chk("wb_fwd_b", hz.fwd_b, 0);
`endif
        idle(3);

        // reset during a load-use stall, then 300 load-use pairs
        drive(1, 9, 0, 1, 0, 1, 1, 1, 0); cycle();
        drive(1, 1, 4, 1, 1, 3, 1, 0, 0);
        rst = 1'b1;
        cycle();
        chk("rs_stall_pre", lastStall, 1);
        rst = 1'b0;
        chk("rs_cnt0", hz.stall_cnt, 0);
        chk("rs_fwd0", hz.fwd_a, 0);
        cycle();
        chk("rs_stall_post", lastStall, 0);
        chk("rs_fwd_a", hz.fwd_a, 0);
        chk("rs_cnt", hz.stall_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            drive(1, 9, 0, 1, 0, 1, 1, 1, 0); cycle();
            drive(1, 1, 4, 1, 1, 3, 1, 0, 0); cycle();
            cycle();
        end
        chk("cnt_300", hz.stall_cnt, 300);

        // randomized traffic with occasional branches and resets
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
